ecsmul_arbiter: RTL and testbench
=================================

// Module: ecsmul_arbiter
// PURPOSE
//   Shares one ecsmul scalar-multiplier core between NREQ requesters.
//   - Round-robin arbitration; one job at a time.
//   - Launch sequence: latch the winning key, hold the core in reset to load it,
//     release the core, wait for done, then return (x,y) tagged with requester id.
//   - Sits between the protocol/key-management clients and the single ecsmul instance.
// PARAMETERS
//   NREQ        4      number of requesters (2..8)
//   KEYW        233    key width; equals core KEYMSB+1
//   TIMEOUT_CYC 65535  RUN-state cycle limit; used only with ECSMUL_ARB_TIMEOUT_EN
// PORTS
//   clk        in   1          single clock
//   rst        in   1          reset: one clock; reset is synchronous and active-high
//   req_valid  in   NREQ       per-requester job request
//   req_key    in   NREQ*KEYW  per-requester scalar; slice i = [i*KEYW +: KEYW]
//   req_ready  out  NREQ       one-hot; 1-cycle pulse = that request accepted
//   rsp_valid  out  1          result available
//   rsp_ready  in   1          consumer accepts result
//   rsp_id     out  3          index of the requester that owns the result
//   rsp_x      out  233        result x (affine)
//   rsp_y      out  233        result y (affine)
//   rsp_err    out  1          job rejected (key==0) or timed out; x=y=0
//   busy       out  1          high in any state other than IDLE
//   core_nrst  out  1          to ecsmul nrst (active low)
//   core_key   out  KEYW       to ecsmul key; registered copy of the granted key
//   core_done  in   1          from ecsmul done
//   core_sx    in   233        from ecsmul sx
//   core_sy    in   233        from ecsmul sy
// BEHAVIOUR
//   Reset (rst=1 at posedge, including mid-job):
//     - state=IDLE, rr_ptr=0, core_nrst=0, core_key=0.
//     - req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_x=rsp_y=0, busy=0.
//     - Any in-flight job is abandoned silently.
//   FSM: IDLE -> LOAD -> RUN -> RESP -> IDLE
//   IDLE (core_nrst=0; core held parked in reset):
//     - Grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping.
//     - On grant, in the same cycle: req_ready[i]=1, latch key into core_key,
//       set rsp_id=i, set rr_ptr=(i+1) mod NREQ.
//     - If the latched key == 0: go straight to RESP with rsp_err=1, x=y=0.
//       The core is never released, because it would never find a leading 1.
//     - Otherwise go to LOAD.
//   LOAD (exactly 2 cycles):
//     - core_nrst=0 and core_key stable, so the core loads the key and clears its
//       state to 0.
//   RUN:
//     - core_nrst=1.
//     - core_done is ignored in the first RUN cycle, so a stale done cannot
//       complete the job.
//     - On core_done=1: capture core_sx/core_sy into rsp_x/rsp_y and go to RESP.
//   RESP:
//     - rsp_valid=1; rsp_x, rsp_y, rsp_id, rsp_err held stable until rsp_ready=1.
//     - Transfer happens on the cycle with rsp_valid & rsp_ready; next cycle is IDLE
//       with rsp_valid=0.
//     - core_nrst=0 in RESP.
//   Request side:
//     - req_ready is only ever asserted in IDLE, never in the same cycle as rsp_valid.
//     - Requests arriving during a job wait. Requesters hold req_valid and req_key
//       until their req_ready pulse.
//   Latency:
//     - Acceptance at cycle t; core released at t+3.
//     - rsp_valid rises 1 cycle after core_done is sampled.
//   Fairness:
//     - With all requesters continuously valid, grants go 0,1,..,NREQ-1,0,...
//   rsp_id is 3 bits wide; unused upper bits are 0 when NREQ<8.
// CONFIGURATION
//   ECSMUL_ARB_TIMEOUT_EN defined:
//     - A 16-bit counter clears on entry to RUN and increments each RUN cycle.
//     - When it reaches TIMEOUT_CYC without core_done: go to RESP with rsp_err=1,
//       x=y=0, core_nrst=0.
//     - A core_done in that same cycle takes priority, giving a normal result.
//   ECSMUL_ARB_TIMEOUT_EN undefined:
//     - No counter; RUN waits indefinitely and TIMEOUT_CYC is unused.
//     - rsp_err is raised only for key==0.
// TESTING
//   1. Single job: req_valid[2]=1, key=1 -> req_ready=4'b0100 for 1 cycle;
//      core_nrst low 2 cycles; rsp_id=2, rsp_err=0, rsp_x/rsp_y=basepoint x/y.
//   2. Round robin: all 4 valid with keys 2,3,4,5 held, rsp_ready=1 ->
//      grant order 0,1,2,3, then 0; each rsp_x matches reference model k*G.
//   3. Back-pressure: rsp_ready=0 for 50 cycles after rsp_valid ->
//      rsp_* stable and no req_ready pulse; then rsp_ready=1 -> IDLE next cycle.
//   4. Zero key: req_valid[1]=1, key=0 -> rsp_valid 2 cycles after acceptance,
//      rsp_err=1, x=y=0, core_nrst never high.
//   5. Reset mid-RUN: rst=1 for 1 cycle -> all outputs at reset values next cycle,
//      rr_ptr=0; a fresh job then completes correctly.
//   6. Timeout (ECSMUL_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, core_done tied 0) ->
//      rsp_err=1 exactly 101 cycles after entering RUN.

Source files
------------

// File: rtl/ecsmul_arbiter.sv
// ---------------------------------------------------------------------------
// ecsmul_arbiter
//   Shares a single ecsmul scalar-multiplier core between NREQ requesters.
//   Round-robin grant, one job in flight. A granted key is registered onto
//   core_key, and the core is held in reset for two LOAD cycles so it can load
//   the key. The core is then released and the arbiter waits for done. The
//   (x,y) result is returned tagged with the id of the requester that owns it.
//   A zero key is rejected without releasing the core.
//
// Optional feature macro:
//   ECSMUL_ARB_TIMEOUT_EN - RUN-state watchdog. After TIMEOUT_CYC cycles
//                           without done, the job ends with rsp_err=1.
//
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset
//   req_valid  in   NREQ       per-requester job request
//   req_key    in   NREQ*KEYW  per-requester scalar, slice i = [i*KEYW +: KEYW]
//   req_ready  out  NREQ       one-hot acceptance pulse (IDLE only)
//   rsp_valid  out  1          result available
//   rsp_ready  in   1          consumer accepts result
//   rsp_id     out  3          owner of the result
//   rsp_x      out  233        result x
//   rsp_y      out  233        result y
//   rsp_err    out  1          zero key or timeout; x=y=0
//   busy       out  1          not IDLE
//   core_nrst  out  1          core reset, active low (high only in RUN)
//   core_key   out  KEYW       registered copy of the granted key
//   core_done  in   1          core done
//   core_sx    in   233        core result x
//   core_sy    in   233        core result y
// ---------------------------------------------------------------------------
module ecsmul_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned KEYW        = 233,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*KEYW-1:0] req_key,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [232:0]         rsp_x,
    output logic [232:0]         rsp_y,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 core_nrst,
    output logic [KEYW-1:0]      core_key,
    input  logic                 core_done,
    input  logic [232:0]         core_sx,
    input  logic [232:0]         core_sy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [2:0]      rr_ptr;
    logic [2:0]      rr_next;
    logic [2:0]      grant_idx;
    logic            grant_found;
    logic [7:0]      req_v8;
    int unsigned     cand;
    logic [KEYW-1:0] sel_key;

    logic            load_cnt;   // 0 = first LOAD cycle, 1 = second
    logic            first_run;  // high during the first RUN cycle only

    logic            do_grant;
    logic            do_zero;
    logic            do_cap;
    logic            do_tmo;

`ifdef ECSMUL_ARB_TIMEOUT_EN
    logic [15:0]     tmo_cnt;
`else
    logic            unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above rr_ptr,
    // wrapping at NREQ. The request vector is padded to 8 bits so that the
    // 3-bit candidate index always selects a real bit.
    // ------------------------------------------------------------------
    always_comb begin
        req_v8           = '0;
        req_v8[NREQ-1:0] = req_valid;
        grant_found      = 1'b0;
        grant_idx        = '0;
        cand             = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {29'd0, rr_ptr} + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && req_v8[3'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(cand);
            end
        end

        sel_key = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_key = req_key[i*KEYW +: KEYW];
            end
        end

        rr_next = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        req_ready = '0;
        do_grant  = 1'b0;
        do_zero   = 1'b0;
        do_cap    = 1'b0;
        do_tmo    = 1'b0;

        case (state)
            S_IDLE: begin
                // Gated by rst so that no requester sees an acceptance that
                // the reset is about to discard.
                if (grant_found && !rst) begin
                    do_grant = 1'b1;
                    state_d  = S_LOAD;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        req_ready[i] = (grant_idx == 3'(i));
                    end
                end
            end

            S_LOAD: begin
                // The zero check uses the registered key in the first LOAD
                // cycle. A zero key is bounced before the core is released.
                if (load_cnt) begin
                    state_d = S_RUN;
                end else if (core_key == '0) begin
                    do_zero = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RUN: begin
                // A done left over from an earlier job is ignored in the
                // first RUN cycle.
                if (core_done && !first_run) begin
                    do_cap  = 1'b1;
                    state_d = S_RESP;
                end
`ifdef ECSMUL_ARB_TIMEOUT_EN
                else if (tmo_cnt == 16'(TIMEOUT_CYC)) begin
                    do_tmo  = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
        core_nrst = (state == S_RUN);
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and sequencing registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            core_key  <= '0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            load_cnt  <= 1'b0;
            first_run <= 1'b0;
        end else begin
            if (do_grant) begin
                core_key <= sel_key;
                rsp_id   <= grant_idx;
                rr_ptr   <= rr_next;
                rsp_err  <= 1'b0;
                rsp_x    <= '0;
                rsp_y    <= '0;
            end
            if (do_zero || do_tmo) begin
                rsp_err <= 1'b1;
                rsp_x   <= '0;
                rsp_y   <= '0;
            end
            if (do_cap) begin
                rsp_x <= core_sx;
                rsp_y <= core_sy;
            end
            load_cnt  <= (state == S_LOAD) && (state_d == S_LOAD);
            first_run <= (state != S_RUN) && (state_d == S_RUN);
        end
    end

`ifdef ECSMUL_ARB_TIMEOUT_EN
    // Counts from zero in the first RUN cycle; idles at zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_RUN) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ecsmul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ecsmul_arbiter
//   Self-checking bench for ecsmul_arbiter (NREQ=4, KEYW=233, TIMEOUT_CYC=100).
//   The ecsmul core is replaced by a behavioural stand-in. The stand-in loads
//   the key while nrst is low. After release it raises done following `lat`
//   RUN cycles and returns a fixed, invertible function of the key. It can
//   also raise a stale done in the first RUN cycle, and it can be silenced
//   entirely to exercise the watchdog (ECSMUL_ARB_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_ecsmul_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned KEYW = 233;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*KEYW-1:0] req_key;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [232:0]         rsp_x;
    logic [232:0]         rsp_y;
    logic                 rsp_err;
    logic                 busy;
    logic                 core_nrst;
    logic [KEYW-1:0]      core_key;
    logic                 core_done;
    logic [232:0]         core_sx;
    logic [232:0]         core_sy;

    always #5 clk = ~clk;

    ecsmul_arbiter #(
        .NREQ        (NREQ),
        .KEYW        (KEYW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_key   (req_key),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .core_nrst (core_nrst),
        .core_key  (core_key),
        .core_done (core_done),
        .core_sx   (core_sx),
        .core_sy   (core_sy)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [232:0] act, input logic [232:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference results for the core stand-in.
    function automatic logic [232:0] mock_x(input logic [232:0] k);
        return k * 233'd1000003 + 233'd17;
    endfunction

    function automatic logic [232:0] mock_y(input logic [232:0] k);
        return ~k ^ (k << 7);
    endfunction

    // ---------------- core stand-in ----------------
    int unsigned  run_cnt = 0;
    int unsigned  lat = 5;
    bit           stale_mode = 1'b0;
    bit           done_en = 1'b1;
    logic [232:0] key_l;

    always @(posedge clk) begin
        run_cnt <= core_nrst ? run_cnt + 1 : 0;
        if (!core_nrst) key_l <= core_key;
    end

    assign core_done = core_nrst && done_en && ((run_cnt == lat) || (stale_mode && run_cnt == 0));
    assign core_sx   = (run_cnt >= lat) ? mock_x(key_l) : 233'hBAD;
    assign core_sy   = (run_cnt >= lat) ? mock_y(key_l) : 233'hBAD;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]   id;
        logic [232:0] x;
        logic [232:0] y;
        logic         err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t last;

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]       valid;
        logic [3:0][15:0] keys;
        logic [2:0]       exp_id;
        logic             exp_err;
    } vec_t;

    vec_t tbl[8];

    // ---------------- always-on protocol checks ----------------
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_vs_rsp_excl", 233'((req_ready != '0) && rsp_valid), 233'(0));
            chk("ready_onehot0", 233'($onehot0(req_ready)), 233'(1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic drive_keys(input logic [3:0][15:0] keys);
        for (int i = 0; i < 4; i++) req_key[i*KEYW +: KEYW] = 233'(keys[i]);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_busy"}, 233'(busy), 233'(0));
        chk({name, "_core_nrst"}, 233'(core_nrst), 233'(0));
        chk({name, "_core_key"}, 233'(core_key), 233'(0));
        chk({name, "_req_ready"}, 233'(req_ready), 233'(0));
        chk({name, "_rsp_valid"}, 233'(rsp_valid), 233'(0));
        chk({name, "_rsp_err"}, 233'(rsp_err), 233'(0));
        chk({name, "_rsp_id"}, 233'(rsp_id), 233'(0));
        chk({name, "_rsp_x"}, rsp_x, 233'(0));
        chk({name, "_rsp_y"}, rsp_y, 233'(0));
    endtask

    // Waits (bounded) for a grant, checks it, pushes the expected response.
    task automatic wait_grant(input logic [2:0] exp_id, input logic [232:0] key,
                              input logic exp_err, input string name);
        int w = 0;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_grant"}, 233'(req_ready), 233'(4'b0001 << exp_id));
        if (exp_err) sb.push_back('{exp_id, 233'(0), 233'(0), 1'b1});
        else         sb.push_back('{exp_id, mock_x(key), mock_y(key), 1'b0});
    endtask

    // From the acceptance cycle: checks release at +3 (or rejection at +2).
    task automatic track_launch(input logic [3:0] clr, input logic zero, input string name);
        int c = 0;
        int rel = 0;
        int rv = 0;
        bit saw = 1'b0;
        while (c < 12 && rel == 0 && rv == 0) begin
            @(negedge clk);
            c++;
            if (core_nrst) begin
                rel = c;
                saw = 1'b1;
            end
            if (rsp_valid) rv = c;
            if (c == 1) req_valid = req_valid & ~clr;
        end
        if (zero) begin
            chk({name, "_zero_rsp_lat"}, 233'(rv), 233'(2));
            chk({name, "_zero_nrst"}, 233'(saw), 233'(0));
        end else begin
            chk({name, "_release_lat"}, 233'(rel), 233'(3));
        end
    endtask

    // Waits (bounded) for rsp_valid, then compares against the scoreboard.
    task automatic wait_rsp(input int exp_wait, input string name);
        int w = 0;
        while (!rsp_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_rsp_valid"}, 233'(rsp_valid), 233'(1));
        if (exp_wait >= 0) chk({name, "_rsp_lat"}, 233'(w), 233'(exp_wait));
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_sb: got response with no expected entry", name);
        end else begin
            last = sb.pop_front();
            chk({name, "_rsp_id"}, 233'(rsp_id), 233'(last.id));
            chk({name, "_rsp_x"}, rsp_x, last.x);
            chk({name, "_rsp_y"}, rsp_y, last.y);
            chk({name, "_rsp_err"}, 233'(rsp_err), 233'(last.err));
        end
    endtask

    task automatic run_one(input logic [3:0] vmask, input logic [3:0][15:0] keys,
                           input logic [2:0] exp_id, input logic exp_err, input string name);
        req_valid = vmask;
        drive_keys(keys);
        #1;
        wait_grant(exp_id, 233'(keys[exp_id[1:0]]), exp_err, name);
        track_launch(vmask, exp_err, name);
        wait_rsp(exp_err ? -1 : int'(lat) + 1, name);
        @(negedge clk);
        chk({name, "_rsp_drop"}, 233'(rsp_valid), 233'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        logic [3:0][15:0] ks;

        rst       = 1'b1;
        req_valid = '0;
        req_key   = '0;
        rsp_ready = 1'b1;

        // rr_ptr starts at 0 after reset. Expected ids follow round robin.
        tbl[0] = '{4'b0100, {16'd0, 16'd1, 16'd0, 16'd0}, 3'd2, 1'b0};       // single job, key 1
        tbl[1] = '{4'b0010, {16'd0, 16'd0, 16'd0, 16'd0}, 3'd1, 1'b1};       // zero key
        tbl[2] = '{4'b1011, {16'd11, 16'd0, 16'd10, 16'd9}, 3'd3, 1'b0};     // rr=2 -> 3
        tbl[3] = '{4'b0011, {16'd0, 16'd0, 16'd13, 16'd12}, 3'd0, 1'b0};     // rr=0 -> 0
        tbl[4] = '{4'b0011, {16'd0, 16'd0, 16'd13, 16'd12}, 3'd1, 1'b0};     // rr=1 -> 1
        tbl[5] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'hFFFF}, 3'd0, 1'b0};    // rr=2 wraps -> 0
        tbl[6] = '{4'b1000, {16'd0, 16'd0, 16'd0, 16'd0}, 3'd3, 1'b1};       // zero key on 3
        tbl[7] = '{4'b1111, {16'd24, 16'd23, 16'd22, 16'd21}, 3'd0, 1'b0};   // rr=0 -> 0

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 8; n++) begin
            stale_mode = (n % 2) == 1;
            run_one(tbl[n].valid, tbl[n].keys, tbl[n].exp_id, tbl[n].exp_err, $sformatf("vec%0d", n));
        end

        // Reset in the middle of RUN. rr_ptr is 1 here, so requester 1 wins
        // and leaves rr_ptr at 2 until the reset clears it.
        lat        = 30;
        stale_mode = 1'b0;
        ks         = {16'd0, 16'd0, 16'd7, 16'd0};
        req_valid  = 4'b0010;
        drive_keys(ks);
        #1;
        wait_grant(3'd1, 233'd7, 1'b0, "midrst");
        track_launch(4'b0010, 1'b0, "midrst");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst_after");
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_rsp", 233'(rsp_valid), 233'(0));

        // Fairness with every requester held valid; stale done is enabled.
        lat        = 4;
        stale_mode = 1'b1;
        ks         = {16'd5, 16'd4, 16'd3, 16'd2};
        req_valid  = 4'b1111;
        drive_keys(ks);
        #1;
        for (int j = 0; j < 5; j++) begin
            wait_grant(3'(j % 4), 233'(ks[j % 4]), 1'b0, $sformatf("rr%0d", j));
            track_launch(4'b0000, 1'b0, $sformatf("rr%0d", j));
            if (j == 4) req_valid = '0;
            wait_rsp(int'(lat) + 1, $sformatf("rr%0d", j));
            @(negedge clk);
            chk($sformatf("rr%0d_rsp_drop", j), 233'(rsp_valid), 233'(0));
        end
        req_valid = '0;
        @(negedge clk);

        // Back-pressure. rr_ptr is 1, so requester 2 wins over 0. Requester 0
        // stays pending and must not be granted while the response is held.
        lat        = 6;
        stale_mode = 1'b0;
        rsp_ready  = 1'b0;
        ks         = {16'd0, 16'h55, 16'd0, 16'h66};
        req_valid  = 4'b0101;
        drive_keys(ks);
        #1;
        wait_grant(3'd2, 233'h55, 1'b0, "bp");
        track_launch(4'b0100, 1'b0, "bp");
        wait_rsp(int'(lat) + 1, "bp");
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_id !== last.id || rsp_x !== last.x || rsp_y !== last.y ||
                rsp_err !== last.err || req_ready !== 4'b0000) ok = 1'b0;
        end
        chk("bp_hold_stable", 233'(ok), 233'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rsp", 233'(rsp_valid), 233'(0));
        chk("bp_release_grant", 233'(req_ready), 233'(4'b0001));
        wait_grant(3'd0, 233'h66, 1'b0, "bp2");
        track_launch(4'b0001, 1'b0, "bp2");
        wait_rsp(int'(lat) + 1, "bp2");
        @(negedge clk);
        chk("bp2_rsp_drop", 233'(rsp_valid), 233'(0));

`ifdef ECSMUL_ARB_TIMEOUT_EN
        // Silent core: the error response appears 101 cycles after RUN entry.
        done_en   = 1'b0;
        ks        = {16'd0, 16'd0, 16'd0, 16'd3};
        req_valid = 4'b0001;
        drive_keys(ks);
        #1;
        wait_grant(3'd0, 233'd3, 1'b1, "tmo");
        track_launch(4'b0001, 1'b0, "tmo");
        wait_rsp(101, "tmo");
        @(negedge clk);
        chk("tmo_rsp_drop", 233'(rsp_valid), 233'(0));
        done_en = 1'b1;
`endif

        chk("final_idle", 233'(busy), 233'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
